wptr_ctrl_param: RTL and testbench

//  Parametrised write-side pointer controller for the async FIFO; successor to the fixed 16-entry write-pointer block.

---
 rtl/wptr_ctrl_param.sv | 110 +++++++++++
 tb/tb_wptr_ctrl_param.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/wptr_ctrl_param.sv
// Write-side pointer controller for a parametrised async FIFO: binary/Gray write
// pointers, full/almost_full/level against the synchronised Gray read pointer, overflow reporting.
module wptr_ctrl_param #(
  parameter int ADDR_W    = 4,
  parameter int AF_MARGIN = 2,
  parameter int OVF_CNT_W = 8
) (
  input  logic                 wr_clk_i,
  input  logic                 wr_rst_i,
  input  logic                 wr_en_i,
  input  logic [ADDR_W:0]      g_rdptr_sync_i,
  input  logic                 ovf_clr_i,
  output logic [ADDR_W-1:0]    wr_addr_o,
  output logic [ADDR_W:0]      b_wrptr_o,
  output logic [ADDR_W:0]      g_wrptr_o,
  output logic                 full_o,
  output logic                 almost_full_o,
  output logic [ADDR_W:0]      wr_level_o,
  output logic                 wr_ack_o,
  output logic                 overflow_o,
  output logic                 ovf_sticky_o,
  output logic [OVF_CNT_W-1:0] ovf_count_o
);

  localparam int PW    = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;

  logic [PW-1:0]        b_wrptr_q, b_wrptr_d;
  logic [PW-1:0]        g_wrptr_q, g_wrptr_d;
  logic                 full_q, full_d;
  logic                 af_q, af_d;
  logic [PW-1:0]        level_q, level_d;
  logic                 ack_q, ack_d;
  logic                 ovf_q, ovf_d;
  logic                 sticky_q, sticky_d;
  logic [OVF_CNT_W-1:0] count_q, count_d;

  logic          accept;
  logic          ovf_ev;
  logic [PW-1:0] b_rd;
  logic [PW-1:0] full_cmp;

  always_comb begin
    accept    = wr_en_i & ~full_q;
    ovf_ev    = wr_en_i & full_q;

    b_wrptr_d = b_wrptr_q + PW'(accept);
    g_wrptr_d = b_wrptr_d ^ (b_wrptr_d >> 1);

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    b_rd = '0;
    for (int i = 0; i < PW; i++) begin
      b_rd[i] = ^(g_rdptr_sync_i >> i);
    end

    // Full when the write pointer has lapped the read pointer by exactly DEPTH.
    full_cmp = {~g_rdptr_sync_i[PW-1:PW-2], g_rdptr_sync_i[PW-3:0]};
    full_d   = (g_wrptr_d == full_cmp);

    level_d  = b_wrptr_d - b_rd;
    af_d     = (level_d >= PW'(DEPTH - AF_MARGIN));

    ack_d    = accept;
    ovf_d    = ovf_ev;
    sticky_d = ovf_ev | (sticky_q & ~ovf_clr_i);

    count_d  = count_q;
    if (ovf_clr_i) begin
      count_d = OVF_CNT_W'(ovf_ev);
    end else if (ovf_ev && !(&count_q)) begin
      count_d = count_q + OVF_CNT_W'(1);
    end
  end

  always_ff @(posedge wr_clk_i) begin
    if (wr_rst_i) begin
      b_wrptr_q <= '0;
      g_wrptr_q <= '0;
      full_q    <= 1'b0;
      af_q      <= 1'b0;
      level_q   <= '0;
      ack_q     <= 1'b0;
      ovf_q     <= 1'b0;
      sticky_q  <= 1'b0;
      count_q   <= '0;
    end else begin
      b_wrptr_q <= b_wrptr_d;
      g_wrptr_q <= g_wrptr_d;
      full_q    <= full_d;
      af_q      <= af_d;
      level_q   <= level_d;
      ack_q     <= ack_d;
      ovf_q     <= ovf_d;
      sticky_q  <= sticky_d;
      count_q   <= count_d;
    end
  end

  assign wr_addr_o     = b_wrptr_q[ADDR_W-1:0];
  assign b_wrptr_o     = b_wrptr_q;
  assign g_wrptr_o     = g_wrptr_q;
  assign full_o        = full_q;
  assign almost_full_o = af_q;
  assign wr_level_o    = level_q;
  assign wr_ack_o      = ack_q;
  assign overflow_o    = ovf_q;
  assign ovf_sticky_o  = sticky_q;
  assign ovf_count_o   = count_q;

endmodule

// File: tb/tb_wptr_ctrl_param.sv
// Scoreboard bench for wptr_ctrl_param: stimulus pushes expected snapshots from a
// count-based FIFO model; a monitor pops and compares one snapshot per write-clock edge.
module tb_wptr_ctrl_param;

  localparam int ADDR_W    = 4;
  localparam int AF_MARGIN = 2;
  localparam int OVF_CNT_W = 4;
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int PMOD      = 2 * DEPTH;
  localparam int CMAX      = (1 << OVF_CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 wrEn;
  logic [ADDR_W:0]      gRd;
  logic                 ovfClr;
  logic [ADDR_W-1:0]    wrAddr;
  logic [ADDR_W:0]      bWr;
  logic [ADDR_W:0]      gWr;
  logic                 full;
  logic                 almostFull;
  logic [ADDR_W:0]      wrLevel;
  logic                 wrAck;
  logic                 overflow;
  logic                 ovfSticky;
  logic [OVF_CNT_W-1:0] ovfCount;

  wptr_ctrl_param #(.ADDR_W(ADDR_W), .AF_MARGIN(AF_MARGIN), .OVF_CNT_W(OVF_CNT_W)) dut (
    .wr_clk_i(clk), .wr_rst_i(rst), .wr_en_i(wrEn), .g_rdptr_sync_i(gRd), .ovf_clr_i(ovfClr),
    .wr_addr_o(wrAddr), .b_wrptr_o(bWr), .g_wrptr_o(gWr), .full_o(full),
    .almost_full_o(almostFull), .wr_level_o(wrLevel), .wr_ack_o(wrAck),
    .overflow_o(overflow), .ovf_sticky_o(ovfSticky), .ovf_count_o(ovfCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst;
    int b;
    int g;
    int addr;
    int level;
    bit full;
    bit af;
    bit ack;
    bit ovf;
    bit sticky;
    int count;
  } expT;

  expT expQ[$];

  int checkCount = 0;
  int passCount  = 0;

  // Model state: total writes accepted and total entries the reader has consumed.
  int wrCount = 0;
  int rdCount = 0;
  bit mFull = 0, mAf = 0, mAck = 0, mOvf = 0, mSticky = 0;
  int mLevel = 0, mCount = 0;

  function automatic int toGray(int v);
    return v ^ (v >> 1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic applyStimulus(input bit w, input bit clr, input bit r);
    expT e;
    bit accept, ovfEv;
    @(negedge clk);
    wrEn   = w;
    ovfClr = clr;
    rst    = r;
    gRd    = (ADDR_W+1)'(toGray(rdCount % PMOD));
    if (r) begin
      wrCount = 0;
      mFull = 0; mAf = 0; mAck = 0; mOvf = 0; mSticky = 0; mLevel = 0; mCount = 0;
    end else begin
      accept  = w && !mFull;
      ovfEv   = w && mFull;
      wrCount += accept ? 1 : 0;
      mLevel  = wrCount - rdCount;
      mFull   = (mLevel == DEPTH);
      mAf     = (mLevel >= DEPTH - AF_MARGIN);
      mAck    = accept;
      mOvf    = ovfEv;
      mSticky = ovfEv || (mSticky && !clr);
      if (clr) mCount = ovfEv ? 1 : 0;
      else if (ovfEv && mCount < CMAX) mCount++;
    end
    e.rst = r;
    e.b = wrCount % PMOD;
    e.g = toGray(e.b);
    e.addr = wrCount % DEPTH;
    e.level = mLevel;
    e.full = mFull; e.af = mAf; e.ack = mAck; e.ovf = mOvf; e.sticky = mSticky;
    e.count = mCount;
    expQ.push_back(e);
  endtask

  // Monitor: every edge presents a new registered snapshot; compare against the oldest expectation.
  initial begin
    expT e;
    logic [ADDR_W:0] prevG;
    bit prevValid = 0;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("b_wrptr", 32'(bWr), 32'(e.b));
        checkOutput("g_wrptr", 32'(gWr), 32'(e.g));
        checkOutput("wr_addr", 32'(wrAddr), 32'(e.addr));
        checkOutput("wr_level", 32'(wrLevel), 32'(e.level));
        checkOutput("full", 32'(full), 32'(e.full));
        checkOutput("almost_full", 32'(almostFull), 32'(e.af));
        checkOutput("wr_ack", 32'(wrAck), 32'(e.ack));
        checkOutput("overflow", 32'(overflow), 32'(e.ovf));
        checkOutput("ovf_sticky", 32'(ovfSticky), 32'(e.sticky));
        checkOutput("ovf_count", 32'(ovfCount), 32'(e.count));
        if (prevValid && !e.rst)
          checkOutput("g_wrptr_bits_changed", 32'($countones(gWr ^ prevG)), e.ack ? 32'd1 : 32'd0);
        prevG = gWr;
        prevValid = 1;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; wrEn = 1'b0; ovfClr = 1'b0; gRd = '0;
    rdCount = 0;
    applyStimulus(0, 0, 1);
    applyStimulus(1, 1, 1);

    // Fill an empty FIFO, then one rejected write, then the reader frees four entries.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    rdCount = 4;
    applyStimulus(0, 0, 0);

    // Reader trails one behind the registered pointer across the pointer wrap.
    for (int i = 0; i < 40; i++) begin
      rdCount = wrCount - 1;
      applyStimulus(1, 0, 0);
    end

    // Random traffic with a slow reader so the FIFO repeatedly fills and overflows.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0 && rdCount < wrCount)
        rdCount += $urandom_range(1, wrCount - rdCount);
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 0);
    end

    // Saturate the overflow counter, then clear and overflow in the same cycle.
    applyStimulus(0, 1, 0);
    for (int i = 0; i < 2 * DEPTH && !mFull; i++) applyStimulus(1, 0, 0);
    for (int i = 0; i < 20; i++) applyStimulus(1, 0, 0);
    applyStimulus(1, 1, 0);
    applyStimulus(0, 0, 0);

    // Reset mid-burst with wr_en held, then a single write after release.
    rdCount = wrCount;
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0);
    rdCount = 0;
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);

    @(posedge clk);
    #2;
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
